slot_allocator: RTL

SLOT_ALLOCATOR -- requirements
Module: slot_allocator

---
 rtl/slot_allocator_pkg.sv | 19 +
 rtl/slot_allocator_first_free_8.sv | 19 +
 rtl/slot_allocator.sv | 105 ++++++++++
 3 files changed

// File: rtl/slot_allocator_pkg.sv
// slot_allocator_pkg: shared definitions for the slot allocator.
//   NUM_SLOTS   - number of managed slots (8)
//   slot_idx_t  - 3-bit slot index
//   search_t    - 4-bit search result; SEARCH_NONE (8) means no slot is free
//   state_t     - allocator FSM states
package slot_allocator_pkg;
  localparam int NUM_SLOTS = 8;

  typedef logic [2:0] slot_idx_t;
  typedef logic [3:0] search_t;

  localparam search_t SEARCH_NONE = 4'd8;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;
endpackage

// File: rtl/slot_allocator_first_free_8.sv
// first_free_8: combinational lowest-free-slot search.
//   map - 8-bit occupancy map, bit i=1 means slot i is taken
//   idx - index of the lowest clear bit, or SEARCH_NONE (8) when all are set
module first_free_8
  import slot_allocator_pkg::*;
(
  input  logic [7:0] map,
  output search_t    idx
);

  // Scan from the top down so the last (lowest) clear bit wins.
  always_comb begin
    idx = SEARCH_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (!map[i]) idx = search_t'(i);
    end
  end

endmodule

// File: rtl/slot_allocator.sv
// slot_allocator: hands out the lowest free of 8 slots, one per cycle.
//   clk, rst      - clock, synchronous active-high reset
//   alloc_req     - request a slot; granted via alloc_gnt/alloc_idx one cycle later
//   free_vld/idx  - release one slot; releasing a free slot pulses err_dbl_free
//   flush         - release every slot (overrides alloc and free)
//   ready         - allocator out of its post-reset INIT cycle
//   busy_map      - occupancy, bit i=1 means slot i is allocated
//   free_cnt/full - number of free slots, and free_cnt==0
module slot_allocator #(
  parameter int NUM_SLOTS = slot_allocator_pkg::NUM_SLOTS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req,
  output logic       alloc_gnt,
  output logic [2:0] alloc_idx,
  input  logic       free_vld,
  input  logic [2:0] free_idx,
  input  logic       flush,
  output logic       ready,
  output logic [7:0] busy_map,
  output logic [3:0] free_cnt,
  output logic       full,
  output logic       err_dbl_free
);
  import slot_allocator_pkg::*;

  state_t    state_q, state_d;
  logic [7:0] busy_map_q, busy_map_d;
  logic [3:0] free_cnt_q, free_cnt_d;
  logic       alloc_gnt_q, alloc_gnt_d;
  slot_idx_t  alloc_idx_q, alloc_idx_d;
  logic       err_q, err_d;

  search_t search;
  logic    accept, free_hit, free_miss;

  // Search runs on the registered map, so a slot freed this cycle is not
  // visible to a same-cycle request.
  first_free_8 u_first_free (
    .map (busy_map_q),
    .idx (search)
  );

  assign ready     = (state_q == ST_RUN) || (state_q == ST_FULL);
  assign accept    = alloc_req && (state_q == ST_RUN) && (search != SEARCH_NONE);
  assign free_hit  = free_vld &&  busy_map_q[free_idx];
  assign free_miss = free_vld && !busy_map_q[free_idx];

  always_comb begin
    state_d     = state_q;
    busy_map_d  = busy_map_q;
    free_cnt_d  = free_cnt_q;
    alloc_gnt_d = 1'b0;
    alloc_idx_d = alloc_idx_q;
    err_d       = 1'b0;
    if (flush) begin
      busy_map_d = '0;
      free_cnt_d = 4'(NUM_SLOTS);
      state_d    = ST_RUN;
    end else begin
      // free_hit targets a busy bit and accept a clear one, so they never collide.
      if (free_hit) busy_map_d[free_idx] = 1'b0;
      if (accept) begin
        busy_map_d[search[2:0]] = 1'b1;
        alloc_idx_d             = search[2:0];
      end
      alloc_gnt_d = accept;
      err_d       = free_miss;
      free_cnt_d  = free_cnt_q + 4'(free_hit) - 4'(accept);
      unique case (state_q)
        ST_INIT: state_d = ST_RUN;
        ST_RUN:  if (free_cnt_d == 4'd0) state_d = ST_FULL;
        ST_FULL: if (free_cnt_d != 4'd0) state_d = ST_RUN;
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      busy_map_q  <= '0;
      free_cnt_q  <= 4'(NUM_SLOTS);
      alloc_gnt_q <= 1'b0;
      alloc_idx_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_map_q  <= busy_map_d;
      free_cnt_q  <= free_cnt_d;
      alloc_gnt_q <= alloc_gnt_d;
      alloc_idx_q <= alloc_idx_d;
      err_q       <= err_d;
    end
  end

  assign alloc_gnt    = alloc_gnt_q;
  assign alloc_idx    = alloc_idx_q;
  assign busy_map     = busy_map_q;
  assign free_cnt     = free_cnt_q;
  assign full         = (free_cnt_q == 4'd0);
  assign err_dbl_free = err_q;

endmodule
